// File: rtl/keypad_letter_fsm_pkg.sv
// Shared key codes, FSM state type and key validity helper for the keypad letter path.
package keypad_pkg;

    localparam logic [7:0] KEY_1    = 8'h88;
    localparam logic [7:0] KEY_2    = 8'h84;
    localparam logic [7:0] KEY_3    = 8'h82;
    localparam logic [7:0] KEY_A    = 8'h81;
    localparam logic [7:0] KEY_4    = 8'h48;
    localparam logic [7:0] KEY_5    = 8'h44;
    localparam logic [7:0] KEY_6    = 8'h42;
    localparam logic [7:0] KEY_B    = 8'h41;
    localparam logic [7:0] KEY_7    = 8'h28;
    localparam logic [7:0] KEY_8    = 8'h24;
    localparam logic [7:0] KEY_9    = 8'h22;
    localparam logic [7:0] KEY_C    = 8'h21;
    localparam logic [7:0] KEY_STAR = 8'h18;
    localparam logic [7:0] KEY_0    = 8'h14;
    localparam logic [7:0] KEY_HASH = 8'h12;
    localparam logic [7:0] KEY_D    = 8'h11;

    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    function automatic logic one_hot4(input logic [3:0] n);
        return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

    function automatic logic key_valid(input logic [7:0] code);
        return one_hot4(code[7:4]) && one_hot4(code[3:0]);
    endfunction

endpackage

// File: rtl/keypad_letter_fsm_if.sv
// Scanner/game-side signal bundle of the keypad letter FSM.
interface keypad_letter_fsm_if;

    logic [7:0] cur_key;
    logic       strobe;
    logic       letter_ready;
    logic [7:0] letter;
    logic       letter_valid;
    logic [7:0] pend_letter;
    logic       pend_valid;
    logic       clear_pulse;
    logic       scan_mode;
    logic [7:0] bad_key_cnt;

    modport master (
        output cur_key, strobe, letter_ready,
        input  letter, letter_valid, pend_letter, pend_valid,
               clear_pulse, scan_mode, bad_key_cnt
    );

    modport slave (
        input  cur_key, strobe, letter_ready,
        output letter, letter_valid, pend_letter, pend_valid,
               clear_pulse, scan_mode, bad_key_cnt
    );

endinterface

// File: rtl/keypad_letter_fsm_key_decode.sv
// Combinational key classifier: letter group base/size plus '*' and '#' detection.
module keypad_key_decode
    import keypad_pkg::*;
(
    input  logic [7:0] cur_key,
    output logic       is_letter,
    output logic [7:0] base_ascii,
    output logic [2:0] grp_size,
    output logic       is_star,
    output logic       is_hash
);

    always_comb begin
        is_letter  = 1'b0;
        base_ascii = 8'h00;
        grp_size   = 3'd3;
        is_star    = (cur_key == KEY_STAR);
        is_hash    = (cur_key == KEY_HASH);
        case (cur_key)
            KEY_2: begin is_letter = 1'b1; base_ascii = ASCII_A;          end
            KEY_3: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd3;   end
            KEY_4: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd6;   end
            KEY_5: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd9;   end
            KEY_6: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd12;  end
            KEY_7: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd15; grp_size = 3'd4; end
            KEY_8: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd19;  end
            KEY_9: begin is_letter = 1'b1; base_ascii = ASCII_A + 8'd22; grp_size = 3'd4; end
            default: ;
        endcase
    end

endmodule

// File: rtl/keypad_letter_fsm.sv
// Multi-tap keypad letter builder: pending letter, '#' commit, valid/ready handover to game logic.
//  state    | meaning
//  IDLE     | no pending letter
//  PEND     | letter under construction, multi-tap sequence may be open
//  WAIT_ACK | committed letter offered, scanner frozen
module keypad_letter_fsm
    import keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                nRst,
    keypad_letter_fsm_if.slave  kif
);

    localparam logic [CNT_W-1:0] TIMER_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       last_key_q, last_key_d;
    logic             seq_open_q, seq_open_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [7:0]       bad_q, bad_d;
    logic [7:0]       letter_q, letter_d;
    logic             lv_q, lv_d;
    logic [7:0]       pend_letter_q, pend_letter_d;
    logic             pv_q, pv_d;
    logic             clr_q, clr_d;
    logic             scan_q, scan_d;

    logic       is_letter, is_star, is_hash;
    logic [7:0] base_ascii;
    logic [2:0] grp_size;
    logic       take;

    keypad_key_decode u_decode (
        .cur_key    (kif.cur_key),
        .is_letter  (is_letter),
        .base_ascii (base_ascii),
        .grp_size   (grp_size),
        .is_star    (is_star),
        .is_hash    (is_hash)
    );

    // Strobes are not even counted while the scanner should be frozen.
    assign take = kif.strobe && (state_q != WAIT_ACK);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        last_key_d    = last_key_q;
        seq_open_d    = seq_open_q;
        timer_d       = timer_q;
        bad_d         = bad_q;
        letter_d      = letter_q;
        lv_d          = lv_q;
        pend_letter_d = pend_letter_q;
        pv_d          = pv_q;
        clr_d         = 1'b0;
        scan_d        = scan_q;

        if (take && !key_valid(kif.cur_key) && (bad_q != 8'hFF)) begin
            bad_d = bad_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (take && is_letter) begin
                    state_d       = PEND;
                    idx_d         = 2'd0;
                    last_key_d    = kif.cur_key;
                    seq_open_d    = 1'b1;
                    timer_d       = '0;
                    pend_letter_d = base_ascii;
                    pv_d          = 1'b1;
                end else if (take && is_star) begin
                    clr_d = 1'b1;
                end
            end
            PEND: begin
                if (take && is_letter) begin
                    if ((kif.cur_key == last_key_q) && seq_open_q) begin
                        idx_d = ({1'b0, idx_q} == (grp_size - 3'd1)) ? 2'd0 : idx_q + 2'd1;
                    end else begin
                        idx_d      = 2'd0;
                        last_key_d = kif.cur_key;
                    end
                    pend_letter_d = base_ascii + {6'd0, idx_d};
                    seq_open_d    = 1'b1;
                    timer_d       = '0;
                end else if (take && (is_hash || is_star)) begin
                    if (is_hash) begin
                        state_d  = WAIT_ACK;
                        letter_d = pend_letter_q;
                        lv_d     = 1'b1;
                        scan_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        clr_d   = 1'b1;
                    end
                    idx_d         = 2'd0;
                    last_key_d    = 8'h00;
                    seq_open_d    = 1'b0;
                    timer_d       = '0;
                    pend_letter_d = 8'h00;
                    pv_d          = 1'b0;
                end else if (seq_open_q) begin
                    if (timer_q == TIMER_TERM) begin
                        seq_open_d = 1'b0;
                    end else begin
                        timer_d = timer_q + CNT_W'(1);
                    end
                end
            end
            WAIT_ACK: begin
                if (lv_q && kif.letter_ready) begin
                    state_d = IDLE;
                    lv_d    = 1'b0;
                    scan_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= IDLE;
            idx_q         <= 2'd0;
            last_key_q    <= 8'h00;
            seq_open_q    <= 1'b0;
            timer_q       <= '0;
            bad_q         <= 8'h00;
            letter_q      <= 8'h00;
            lv_q          <= 1'b0;
            pend_letter_q <= 8'h00;
            pv_q          <= 1'b0;
            clr_q         <= 1'b0;
            scan_q        <= 1'b1;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            last_key_q    <= last_key_d;
            seq_open_q    <= seq_open_d;
            timer_q       <= timer_d;
            bad_q         <= bad_d;
            letter_q      <= letter_d;
            lv_q          <= lv_d;
            pend_letter_q <= pend_letter_d;
            pv_q          <= pv_d;
            clr_q         <= clr_d;
            scan_q        <= scan_d;
        end
    end

    assign kif.letter       = letter_q;
    assign kif.letter_valid = lv_q;
    assign kif.pend_letter  = pend_letter_q;
    assign kif.pend_valid   = pv_q;
    assign kif.clear_pulse  = clr_q;
    assign kif.scan_mode    = scan_q;
    assign kif.bad_key_cnt  = bad_q;

endmodule

// File: tb/tb_keypad_letter_fsm.sv
// Bench for keypad_letter_fsm: stimulus table plus hand-written timeout, saturation and reset sequences.
module tb_keypad_letter_fsm;

    typedef struct packed {
        logic [7:0]  key;
        logic        stb;
        logic        rdy;
        logic [27:0] exp;
    } vec_t;

    localparam logic [27:0] RST_EXP = {8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};

    logic clk = 1'b0;
    logic nRst;
    always #5 clk = ~clk;

    keypad_letter_fsm_if kif();

    keypad_letter_fsm #(.TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .nRst (nRst),
        .kif  (kif)
    );

    int          n_checks = 0;
    int          n_err    = 0;
    logic [27:0] sb[$];
    vec_t        vecs[$];

    function automatic vec_t mk(logic [7:0] k, logic s, logic r, logic [7:0] p, logic pv,
                                logic [7:0] l, logic lv, logic c, logic sc, logic [7:0] b);
        vec_t v;
        v.key = k;
        v.stb = s;
        v.rdy = r;
        v.exp = {p, pv, l, lv, c, sc, b};
        return v;
    endfunction

    function logic [27:0] outs();
        return {kif.pend_letter, kif.pend_valid, kif.letter, kif.letter_valid,
                kif.clear_pulse, kif.scan_mode, kif.bad_key_cnt};
    endfunction

    task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {pend,pv,let,lv,clr,scan,bad}=%h expected %h", name, got, exp);
        end
    endtask

    task automatic step(input string name, input vec_t v);
        kif.cur_key      = v.key;
        kif.strobe       = v.stb;
        kif.letter_ready = v.rdy;
        sb.push_back(v.exp);
        @(posedge clk);
        @(negedge clk);
        check(name, outs(), sb.pop_front());
    endtask

    task automatic idle(input int n);
        kif.strobe       = 1'b0;
        kif.letter_ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // multi-tap ABC, commit with ready already high
        vecs.push_back(mk(8'h84,1,0, 8'h41,1, 8'h00,0,0,1, 8'h00));
        vecs.push_back(mk(8'h84,1,0, 8'h42,1, 8'h00,0,0,1, 8'h00));
        vecs.push_back(mk(8'h84,1,0, 8'h43,1, 8'h00,0,0,1, 8'h00));
        vecs.push_back(mk(8'h12,1,1, 8'h00,0, 8'h43,1,0,0, 8'h00));
        vecs.push_back(mk(8'h00,0,1, 8'h00,0, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h00,0,0, 8'h00,0, 8'h43,0,0,1, 8'h00));
        // WXYZ wrap, delayed ready
        vecs.push_back(mk(8'h22,1,0, 8'h57,1, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h22,1,0, 8'h58,1, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h22,1,0, 8'h59,1, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h22,1,0, 8'h5A,1, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h22,1,0, 8'h57,1, 8'h43,0,0,1, 8'h00));
        vecs.push_back(mk(8'h12,1,0, 8'h00,0, 8'h57,1,0,0, 8'h00));
        vecs.push_back(mk(8'h00,0,0, 8'h00,0, 8'h57,1,0,0, 8'h00));
        vecs.push_back(mk(8'h00,0,1, 8'h00,0, 8'h57,0,0,1, 8'h00));
        // key change replaces, '*' clears
        vecs.push_back(mk(8'h48,1,0, 8'h47,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h42,1,0, 8'h4D,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h57,0,1,1, 8'h00));
        vecs.push_back(mk(8'h00,0,0, 8'h00,0, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h84,1,0, 8'h41,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h82,1,0, 8'h44,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h84,1,0, 8'h41,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h57,0,1,1, 8'h00));
        // PQRS wrap, ignored 'A' key in PEND
        vecs.push_back(mk(8'h28,1,0, 8'h50,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h28,1,0, 8'h51,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h28,1,0, 8'h52,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h28,1,0, 8'h53,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h28,1,0, 8'h50,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h81,1,0, 8'h50,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h57,0,1,1, 8'h00));
        // TUV wrap at 3
        vecs.push_back(mk(8'h24,1,0, 8'h54,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h24,1,0, 8'h55,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h24,1,0, 8'h56,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h24,1,0, 8'h54,1, 8'h57,0,0,1, 8'h00));
        vecs.push_back(mk(8'h12,1,1, 8'h00,0, 8'h54,1,0,0, 8'h00));
        vecs.push_back(mk(8'h00,0,1, 8'h00,0, 8'h54,0,0,1, 8'h00));
        // WAIT_ACK ignores strobes including '*'
        vecs.push_back(mk(8'h82,1,0, 8'h44,1, 8'h54,0,0,1, 8'h00));
        vecs.push_back(mk(8'h12,1,0, 8'h00,0, 8'h44,1,0,0, 8'h00));
        vecs.push_back(mk(8'h84,1,0, 8'h00,0, 8'h44,1,0,0, 8'h00));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h44,1,0,0, 8'h00));
        vecs.push_back(mk(8'h00,0,1, 8'h00,0, 8'h44,0,0,1, 8'h00));
        vecs.push_back(mk(8'h84,1,1, 8'h41,1, 8'h44,0,0,1, 8'h00));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h44,0,1,1, 8'h00));
        // invalid codes counted, ignored keys not
        vecs.push_back(mk(8'h00,1,0, 8'h00,0, 8'h44,0,0,1, 8'h01));
        vecs.push_back(mk(8'hC4,1,0, 8'h00,0, 8'h44,0,0,1, 8'h02));
        vecs.push_back(mk(8'h88,1,0, 8'h00,0, 8'h44,0,0,1, 8'h02));
        vecs.push_back(mk(8'h12,1,0, 8'h00,0, 8'h44,0,0,1, 8'h02));
        vecs.push_back(mk(8'h84,1,0, 8'h41,1, 8'h44,0,0,1, 8'h02));
        vecs.push_back(mk(8'h03,1,0, 8'h41,1, 8'h44,0,0,1, 8'h03));
        vecs.push_back(mk(8'h18,1,0, 8'h00,0, 8'h44,0,1,1, 8'h03));
        vecs.push_back(mk(8'h84,1,0, 8'h41,1, 8'h44,0,0,1, 8'h03));
        vecs.push_back(mk(8'h12,1,0, 8'h00,0, 8'h41,1,0,0, 8'h03));
        vecs.push_back(mk(8'h00,1,0, 8'h00,0, 8'h41,1,0,0, 8'h03));
        vecs.push_back(mk(8'h00,0,1, 8'h00,0, 8'h41,0,0,1, 8'h03));

        nRst             = 1'b0;
        kif.cur_key      = 8'h00;
        kif.strobe       = 1'b0;
        kif.letter_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", outs(), RST_EXP);
        nRst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // sequence closes after the idle timeout: same key restarts the group
        step("to_first",  mk(8'h44,1,0, 8'h4A,1, 8'h41,0,0,1, 8'h03));
        idle(20);
        step("to_closed", mk(8'h44,1,0, 8'h4A,1, 8'h41,0,0,1, 8'h03));
        idle(5);
        step("to_open",   mk(8'h44,1,0, 8'h4B,1, 8'h41,0,0,1, 8'h03));
        step("to_clear",  mk(8'h18,1,0, 8'h00,0, 8'h41,0,1,1, 8'h03));

        kif.cur_key = 8'hC4;
        kif.strobe  = 1'b1;
        repeat (260) @(negedge clk);
        step("bad_sat", mk(8'h00,0,0, 8'h00,0, 8'h41,0,0,1, 8'hFF));

        step("pre_rst", mk(8'h84,1,0, 8'h41,1, 8'h41,0,0,1, 8'hFF));
        kif.strobe = 1'b0;
        #2 nRst = 1'b0;
        #1 check("async_rst", outs(), RST_EXP);
        @(negedge clk);
        nRst = 1'b1;
        step("post_rst", mk(8'h00,0,0, 8'h00,0, 8'h00,0,0,1, 8'h00));
        step("post_rst_key", mk(8'h84,1,0, 8'h41,1, 8'h00,0,0,1, 8'h00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
